// File: rtl/pwm_sched_pkg.sv
// rtl/pwm_sched_pkg.sv - shared types and helpers for the PWM duty scheduler
// Scheduler state encoding, default duty width and FIFO level-width helper.
package pwm_sched_pkg;

  localparam int DUTY_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    ALIGNING,
    RUN,
    STOP
  } sched_state_e;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pwm_duty_fifo.sv
// rtl/pwm_duty_fifo.sv - DEPTH x DUTY_W duty sample FIFO
// Synchronous FIFO with occupancy count; push and pop in one cycle are both honoured.
module pwm_duty_fifo
  import pwm_sched_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DEPTH  = 4,
  localparam int LW    = level_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DUTY_W-1:0] push_data,
  input  logic              pop,
  output logic [DUTY_W-1:0] head,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [DUTY_W-1:0] mem_q [DEPTH];
  logic [DUTY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// rtl/pwm_duty_scheduler.sv - applies FIFO'd duty samples to the PWM once per period
// Optional PWM_DUTY_SLEW_EN limits each duty change to MAX_STEP per boundary.
module pwm_duty_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int DEPTH    = 4,
  parameter int ALIGN    = 1,
`ifdef PWM_DUTY_SLEW_EN
  parameter int MAX_STEP = 16,
`endif
  localparam int LW      = level_w(DEPTH)
) (
  input  logic              ipClk,
  input  logic              ipReset,
  input  logic              ipEnable,
  input  logic [DUTY_W-1:0] ipDuty,
  input  logic              ipValid,
  output logic              opReady,
  output logic [DUTY_W-1:0] opDutyCycle,
  output logic              opPWMHold,
  output logic              opPeriodStart,
  output logic              opUnderrun,
  input  logic              ipClearUnderrun,
  output logic [LW-1:0]     opLevel
);

  localparam int ALW = (ALIGN > 1) ? $clog2(ALIGN) : 1;

  sched_state_e      state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] phase_q, phase_d;
  logic [ALW-1:0]    align_q, align_d;
  logic              hold_q, hold_d;
  logic              pstart_q, pstart_d;
  logic              under_q, under_d;
  logic              rdy_en_q, rdy_en_d;
  logic [DUTY_W-1:0] head, next_duty;
  logic [LW-1:0]     level;
  logic              push, pop, pop_ok, full, empty;

  // Ready is held low until the first clock after reset release.
  assign rdy_en_d      = 1'b1;
  assign opReady       = rdy_en_q && !full;
  assign push          = ipValid && opReady;
  assign opDutyCycle   = duty_q;
  assign opPWMHold     = hold_q;
  assign opPeriodStart = pstart_q;
  assign opUnderrun    = under_q;
  assign opLevel       = level;

  pwm_duty_fifo #(
    .DUTY_W(DUTY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (ipClk),
    .rst_n    (ipReset),
    .push     (push),
    .push_data(ipDuty),
    .pop      (pop),
    .head     (head),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

`ifdef PWM_DUTY_SLEW_EN
  function automatic logic [DUTY_W-1:0] slew_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    int c, t;
    c = int'(cur);
    t = int'(tgt);
    if (t > c + MAX_STEP) return DUTY_W'(c + MAX_STEP);
    if (t < c - MAX_STEP) return DUTY_W'(c - MAX_STEP);
    return tgt;
  endfunction

  assign next_duty = slew_toward(duty_q, head);
`else
  assign next_duty = head;
`endif

  // A sample leaves the FIFO only once the applied duty has reached it.
  assign pop_ok = (next_duty == head);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    hold_d   = hold_q;
    pstart_d = 1'b0;
    phase_d  = '0;
    align_d  = align_q;
    pop      = 1'b0;
    under_d  = ipClearUnderrun ? 1'b0 : under_q;
    unique case (state_q)
      IDLE: begin
        hold_d = 1'b1;
        duty_d = '0;
        if (ipEnable && !empty) state_d = PRIME;
      end
      PRIME: begin
        duty_d  = next_duty;
        pop     = pop_ok;
        hold_d  = 1'b0;
        align_d = '0;
        if (ALIGN == 0) begin
          state_d  = RUN;
          pstart_d = 1'b1;
        end else begin
          state_d = ALIGNING;
        end
      end
      ALIGNING: begin
        if (align_q == ALW'(ALIGN - 1)) begin
          state_d  = RUN;
          pstart_d = 1'b1;
        end else begin
          align_d = align_q + 1'b1;
        end
      end
      RUN: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == '1) begin
          if (!ipEnable) begin
            state_d = STOP;
            hold_d  = 1'b1;
            duty_d  = '0;
          end else begin
            pstart_d = 1'b1;
            if (!empty) begin
              duty_d = next_duty;
              pop    = pop_ok;
            end else begin
              under_d = 1'b1;
            end
          end
        end
      end
      STOP: begin
        hold_d  = 1'b1;
        duty_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      phase_q  <= '0;
      align_q  <= '0;
      hold_q   <= 1'b1;
      pstart_q <= 1'b0;
      under_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      align_q  <= align_d;
      hold_q   <= hold_d;
      pstart_q <= pstart_d;
      under_q  <= under_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// tb/tb_pwm_duty_scheduler.sv - self-checking bench for pwm_duty_scheduler
// Defining PWM_DUTY_SLEW_EN runs the slew-limited sequence instead of the default one.
module tb_pwm_duty_scheduler;

  localparam int DUTY_W   = 8;
  localparam int DEPTH    = 4;
  localparam int ALIGN    = 1;
  localparam int PER      = 1 << DUTY_W;
  localparam int MAX_STEP = 16;
`ifdef PWM_DUTY_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic       ipClk           = 1'b0;
  logic       ipReset         = 1'b0;
  logic       ipEnable        = 1'b0;
  logic       ipValid         = 1'b0;
  logic       ipClearUnderrun = 1'b0;
  logic [7:0] ipDuty          = 8'h00;
  logic       opReady, opPWMHold, opPeriodStart, opUnderrun;
  logic [7:0] opDutyCycle;
  logic [2:0] opLevel;

  int vectors     = 0;
  int miscompares = 0;

  typedef enum int {M_IDLE, M_PRIME, M_RUN, M_STOP} mmode_e;
  mmode_e m_mode;
  int     m_t;
  int     m_duty;
  bit     m_hold, m_ps, m_under, m_rdy_en, m_acc;
  int     q[$];

  pwm_duty_scheduler #(
    .DUTY_W(DUTY_W),
    .DEPTH (DEPTH),
    .ALIGN (ALIGN)
  ) dut (
    .ipClk          (ipClk),
    .ipReset        (ipReset),
    .ipEnable       (ipEnable),
    .ipDuty         (ipDuty),
    .ipValid        (ipValid),
    .opReady        (opReady),
    .opDutyCycle    (opDutyCycle),
    .opPWMHold      (opPWMHold),
    .opPeriodStart  (opPeriodStart),
    .opUnderrun     (opUnderrun),
    .ipClearUnderrun(ipClearUnderrun),
    .opLevel        (opLevel)
  );

  always #5 ipClk = ~ipClk;

  function automatic int approach(input int cur, input int tgt);
    if (SLEW && tgt > cur + MAX_STEP) return cur + MAX_STEP;
    if (SLEW && tgt < cur - MAX_STEP) return cur - MAX_STEP;
    return tgt;
  endfunction

  function automatic bit m_ready();
    return m_rdy_en && (q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode   = M_IDLE;
    m_t      = 0;
    m_duty   = 0;
    m_hold   = 1'b1;
    m_ps     = 1'b0;
    m_under  = 1'b0;
    m_rdy_en = 1'b0;
    m_acc    = 1'b0;
  endtask

  // Model: t counts cycles since hold fell; PWM phase is (t - ALIGN) mod PER.
  task automatic model_step();
    bit acc, pop, ps, u, bnd;
    int nd, p, nt;
    acc = ipValid && m_ready();
    pop = 1'b0;
    ps  = 1'b0;
    u   = ipClearUnderrun ? 1'b0 : m_under;
    case (m_mode)
      M_IDLE: begin
        m_hold = 1'b1;
        m_duty = 0;
        if (ipEnable && q.size() > 0) m_mode = M_PRIME;
      end
      M_PRIME: begin
        nd     = approach(m_duty, q[0]);
        pop    = (nd == q[0]);
        m_duty = nd;
        m_hold = 1'b0;
        m_t    = 0;
        m_mode = M_RUN;
        ps     = (ALIGN == 0);
      end
      M_RUN: begin
        p   = m_t - ALIGN;
        bnd = (p >= 0) && (p % PER == PER - 1);
        if (bnd && !ipEnable) begin
          m_mode = M_STOP;
          m_hold = 1'b1;
          m_duty = 0;
        end else begin
          if (bnd && q.size() > 0) begin
            nd     = approach(m_duty, q[0]);
            pop    = (nd == q[0]);
            m_duty = nd;
          end else if (bnd) begin
            u = 1'b1;
          end
          m_t++;
          nt = m_t - ALIGN;
          ps = (nt >= 0) && (nt % PER == 0);
        end
      end
      M_STOP: begin
        m_mode = M_IDLE;
        m_hold = 1'b1;
        m_duty = 0;
      end
      default: ;
    endcase
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(int'(ipDuty));
    m_acc    = acc;
    m_ps     = ps;
    m_under  = u;
    m_rdy_en = 1'b1;
  endtask

  task automatic compare_all();
    vectors++;
    if (opDutyCycle !== 8'(m_duty) || opPWMHold !== m_hold || opPeriodStart !== m_ps ||
        opUnderrun !== m_under || opLevel !== 3'(q.size()) || opReady !== m_ready()) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t duty/hold/pstart/under/level/ready got %02h/%0b/%0b/%0b/%0d/%0b expected %02h/%0b/%0b/%0b/%0d/%0b",
               $time, opDutyCycle, opPWMHold, opPeriodStart, opUnderrun, opLevel, opReady,
               8'(m_duty), m_hold, m_ps, m_under, q.size(), m_ready());
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ipClk);
    model_step();
    @(negedge ipClk);
    compare_all();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_sample(input logic [7:0] d);
    int n;
    n       = 0;
    ipValid = 1'b1;
    ipDuty  = d;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 16);
    ipValid = 1'b0;
    if (!m_acc) check("push_timeout", 0, 1);
  endtask

  task automatic async_reset_check();
    #1;
    ipReset  = 1'b0;
    ipEnable = 1'b0;
    model_reset();
    #1;
    check("arst_hold", opPWMHold, 1);
    check("arst_duty", opDutyCycle, 0);
    check("arst_level", opLevel, 0);
    check("arst_ready", opReady, 0);
    check("arst_pstart", opPeriodStart, 0);
    @(negedge ipClk);
    ipReset = 1'b1;
    tick();
    check("ready_after_release", opReady, 1);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_hold", opPWMHold, 1);
    check("rst_duty", opDutyCycle, 0);
    check("rst_ready", opReady, 0);
    check("rst_level", opLevel, 0);
    check("rst_under", opUnderrun, 0);
    check("rst_pstart", opPeriodStart, 0);
    @(negedge ipClk);
    ipReset = 1'b1;
    tick();
    check("ready_after_release", opReady, 1);

`ifdef PWM_DUTY_SLEW_EN
    push_sample(8'h50);
    ipEnable = 1'b1;
    tick_n(2);
    check("slew_prime_duty", opDutyCycle, 8'h10);
    check("slew_prime_level", opLevel, 1);
    tick();
    for (int k = 2; k <= 5; k++) begin
      tick_n(PER);
      check("slew_duty", opDutyCycle, 32'(16 * k));
      check("slew_level", opLevel, (k == 5) ? 0 : 1);
    end
    ipEnable = 1'b0;
    tick_n(PER);
    check("slew_stop_hold", opPWMHold, 1);
    check("slew_stop_duty", opDutyCycle, 0);
    tick();
`else
    // Three back-to-back periods, then stop requested mid-period.
    push_sample(8'h40);
    push_sample(8'h80);
    push_sample(8'hC0);
    check("t1_level3", opLevel, 3);
    ipEnable = 1'b1;
    tick();
    check("t1_prime_hold", opPWMHold, 1);
    tick();
    check("t1_hold_fall", opPWMHold, 0);
    check("t1_duty40", opDutyCycle, 8'h40);
    check("t1_level2", opLevel, 2);
    tick();
    check("t1_pstart0", opPeriodStart, 1);
    tick_n(PER);
    check("t1_pstart1", opPeriodStart, 1);
    check("t1_duty80", opDutyCycle, 8'h80);
    tick_n(PER);
    check("t1_dutyC0", opDutyCycle, 8'hC0);
    check("t1_level0", opLevel, 0);
    tick_n(100);
    ipEnable = 1'b0;
    tick_n(155);
    check("t4_no_truncate_hold", opPWMHold, 0);
    check("t4_no_truncate_duty", opDutyCycle, 8'hC0);
    tick();
    check("t4_stop_hold", opPWMHold, 1);
    check("t4_stop_duty", opDutyCycle, 0);
    check("t4_stop_pstart", opPeriodStart, 0);
    tick();

    // Fill to DEPTH, reject a fifth sample, then reset asynchronously mid-run.
    push_sample(8'hFF);
    push_sample(8'h00);
    push_sample(8'h33);
    push_sample(8'h44);
    check("t2_full_level", opLevel, 4);
    check("t2_full_ready", opReady, 0);
    ipValid = 1'b1;
    ipDuty  = 8'h55;
    tick_n(3);
    check("t2_fifth_rejected", opLevel, 4);
    ipValid  = 1'b0;
    ipEnable = 1'b1;
    tick_n(2);
    check("t2_dutyFF", opDutyCycle, 8'hFF);
    tick();
    tick_n(PER);
    check("t2_duty00", opDutyCycle, 8'h00);
    check("t2_level2", opLevel, 2);
    tick_n(50);
    async_reset_check();

    // Underrun with a push landing on the empty boundary, then clear vs. set.
    push_sample(8'h20);
    ipEnable = 1'b1;
    tick_n(3);
    check("t3_duty20", opDutyCycle, 8'h20);
    tick_n(PER - 1);
    ipValid = 1'b1;
    ipDuty  = 8'h99;
    tick();
    ipValid = 1'b0;
    check("t3_underrun_set", opUnderrun, 1);
    check("t3_duty_held", opDutyCycle, 8'h20);
    check("t3_late_push_level", opLevel, 1);
    tick_n(PER);
    check("t3_duty99", opDutyCycle, 8'h99);
    check("t3_underrun_sticky", opUnderrun, 1);
    ipClearUnderrun = 1'b1;
    tick();
    ipClearUnderrun = 1'b0;
    check("t3_underrun_cleared", opUnderrun, 0);
    tick_n(PER - 2);
    ipClearUnderrun = 1'b1;
    tick();
    ipClearUnderrun = 1'b0;
    check("t3_set_wins", opUnderrun, 1);
    check("t3_duty99_held", opDutyCycle, 8'h99);
    ipEnable = 1'b0;
    tick_n(PER);
    check("t3_stop_hold", opPWMHold, 1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
